// File: rtl/mul_tree_result_collector.sv
// Collects skewed per-lane tree results into mode-dependent frames, buffers them in a small FIFO
// and hands them out over valid/ready. Optional counters: define COLLECT_FRAME_CNT_EN.
module mul_tree_result_collector #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic [4*DW-1:0]          in_data,
    input  logic [3:0]               in_stb,
    output logic [4*DW-1:0]          out_data,
    output logic [3:0]               out_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_err,
    output logic                     dup_err,
    input  logic                     clr_err
`ifdef COLLECT_FRAME_CNT_EN
    ,
    output logic [15:0]              frame_cnt,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = 4*DW + 4;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [1:0]      r_mode_q;
    logic [3:0]      r_pending;
    logic [DW-1:0]   r_lane [4];
    logic [FW-1:0]   r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_ovf_err;
    logic            r_dup_err;

    logic            w_mode_chg;
    logic [3:0]      w_exp;
    logic [3:0]      w_acc;
    logic [3:0]      w_covered;
    logic            w_complete;
    logic            w_dup;
    logic [DW-1:0]   w_merged [4];
    logic [4*DW-1:0] w_frame_data;
    logic [AW:0]     w_level;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    always_comb begin
        w_exp = 4'b0001;
        case (mode)
            2'b00:   w_exp = 4'b1111;
            2'b01:   w_exp = 4'b0011;
            default: w_exp = 4'b0001;
        endcase
    end

    // A mode switch throws away the partial frame and every strobe of that cycle.
    assign w_mode_chg = (mode != r_mode_q);
    assign w_acc      = w_mode_chg ? 4'b0000 : (in_stb & w_exp);
    assign w_dup      = |(w_acc & r_pending);
    assign w_covered  = (r_pending | w_acc) & w_exp;
    assign w_complete = !w_mode_chg && (w_covered == w_exp);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[gi] = w_acc[gi] ? in_data[gi*DW +: DW] : r_lane[gi];
            assign w_frame_data[gi*DW +: DW] = w_exp[gi] ? w_merged[gi] : '0;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_lane[gi] <= '0;
                end else if (w_acc[gi]) begin
                    r_lane[gi] <= in_data[gi*DW +: DW];
                end
            end
        end
    endgenerate

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == FULL_LEVEL);
    assign w_empty = (w_level == '0);
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still takes the frame when the head leaves in the same cycle.
    assign w_push  = w_complete && (!w_full || w_pop);
    assign w_drop  = w_complete && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_q  <= 2'b00;
            r_pending <= 4'b0000;
        end else begin
            r_mode_q <= mode;
            if (w_mode_chg || w_complete) begin
                r_pending <= 4'b0000;
            end else begin
                r_pending <= r_pending | w_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {w_exp, w_frame_data};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_err <= 1'b0;
            r_dup_err <= 1'b0;
        end else begin
            if (w_drop)       r_ovf_err <= 1'b1;
            else if (clr_err) r_ovf_err <= 1'b0;
            if (w_dup)        r_dup_err <= 1'b1;
            else if (clr_err) r_dup_err <= 1'b0;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]][4*DW-1:0];
    assign out_mask  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]][FW-1:4*DW];
    assign level     = w_level;
    assign ovf_err   = r_ovf_err;
    assign dup_err   = r_dup_err;

`ifdef COLLECT_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_pop) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule
